fpu_adder_arbiter: RTL and testbench
====================================

Name: fpu_adder_arbiter

Overview:
Shares one single-precision FP adder between NUM_REQ requesters using round-robin arbitration. The block accepts an operand pair from the granted requester and drives the adder's three-phase a/b/z strobe-ack handshake. It then returns the 32-bit result to the same requester only. It sits between the requesting datapath units and the adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of grant index, equal to clog2(NUM_REQ)

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  NUM_REQ  per-requester operand pair valid
req_a  in  32*NUM_REQ  operand A; slice i belongs to requester i
req_b  in  32*NUM_REQ  operand B; slice i belongs to requester i
req_ready  out  NUM_REQ  one-hot accept; transfer on valid&ready
resp_valid  out  NUM_REQ  one-hot result valid, to owner only
resp_data  out  32  result word, shared by all requesters
resp_ready  in  NUM_REQ  per-requester result accept
adder_a  out  32  operand to adder input_a
adder_a_stb  out  1  to adder input_a_stb
adder_a_ack  in  1  from adder input_a_ack
adder_b  out  32  operand to adder input_b
adder_b_stb  out  1  to adder input_b_stb
adder_b_ack  in  1  from adder input_b_ack
adder_z  in  32  from adder output_z
adder_z_stb  in  1  from adder output_z_stb
adder_z_ack  out  1  to adder output_z_ack
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - Reset state: state=IDLE, last_grant=NUM_REQ-1, so requester 0 has top priority.
  - All outputs go to 0 on reset: stb, ack, req_ready, resp_valid, resp_data, adder_a, adder_b.
- IDLE:
  - req_ready[g] is combinational and equals 1 only for g, the first i with req_valid[i] set, searching from last_grant+1 with wrap.
  - At that edge: latch op_a, op_b, owner=g, then go to SEND_A.
  - No request pending: stay in IDLE with req_ready=0.
- SEND_A:
  - adder_a_stb=1, adder_a=op_a.
  - On the edge where adder_a_stb && adder_a_ack: go to SEND_B.
- SEND_B:
  - adder_b_stb=1, adder_b=op_b.
  - On the edge where adder_b_stb && adder_b_ack: go to WAIT_Z.
- WAIT_Z:
  - adder_z_ack=1.
  - On the edge where adder_z_stb && adder_z_ack: capture res=adder_z, then go to RESP.
- RESP:
  - resp_valid[owner]=1, resp_data=res.
  - On the edge where resp_ready[owner]: set last_grant=owner and go to IDLE.
- Handshake rules:
  - All stb/ack/valid outputs are decodes of registered state. Nothing depends combinationally on adder ack inputs.
  - Exception: req_ready depends combinationally on req_valid.
  - Outputs hold stable while waiting; no timeout.
- Latency from accept to resp_valid: 3 + adder pipeline + handshake waits. Minimum is 2 cycles per adder handshake phase, because the adder raises ack one cycle after entering its state.
- Only one operation is in flight at a time. New requests stall in IDLE arbitration until the response is taken.
- Boundary conditions:
  - Requests that arrive simultaneously: rotation guarantees each requester is served within NUM_REQ operations.
  - A requester that drops req_valid before grant: no effect.
  - resp_ready of non-owners is ignored.
  - Reset mid-operation: the in-flight op is discarded with no response. The adder must share the same rst.
- Arithmetic: none on data. Operands and result pass bit-exact.

Decomposition:
- Package fpu_arb_pkg: state encoding (IDLE=0, SEND_A=1, SEND_B=2, WAIT_Z=3, RESP=4; 3-bit), FP word width constant 32.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, index, any.

Test Plan:
- After reset, req_valid[0]=1 with A=0x3F800000, B=0x40000000 -> req_ready[0] pulses for 1 cycle; adder_a/adder_b carry those words; resp_valid[0] with resp_data=0x40400000; busy=0 afterward.
- req_valid=4'b0101 held continuously -> grant order 0,2,0,2; req_ready never goes to 1 or 3.
- All four requesters valid continuously for 8 ops -> grant sequence 0,1,2,3,0,1,2,3.
- Owner 1 holds resp_ready=0 for 10 cycles -> resp_valid[1] and resp_data hold stable; no new req_ready during that time; release -> IDLE next cycle.
- A=0xC0A00000, B=0x40A00000 -> resp_data=0x00000000; stalled adder_a_ack (held low 5 cycles) -> adder_a_stb and adder_a remain stable throughout.
- rst asserted during WAIT_Z -> next cycle state=IDLE, busy=0, no resp_valid; a following request completes normally starting with requester 0 priority.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FP adder arbiter: FSM state encoding and word width.
package fpu_arb_pkg;

  localparam int unsigned FpW = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSendA = 3'd1,
    StSendB = 3'd2,
    StWaitZ = 3'd3,
    StResp  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, with wrap.
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    last_grant,
  output logic [NumReq-1:0] gnt,
  output logic [IdW-1:0]    idx,
  output logic              any
);

  logic [31:0]    cand;
  logic [IdW-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = '0;
    cand_idx = '0;
    // Offsets 1..NumReq visit every requester once, last_grant itself last.
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand     = (32'(last_grant) + k) % NumReq;
      cand_idx = IdW'(cand);
      if (!any && req[cand_idx]) begin
        any           = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fpu_adder_arbiter.sv
// Round-robin sharing of one FP adder; drives the a/b/z strobe-ack handshake and
// routes the result back to the requester that issued the operands.
module fpu_adder_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [31:0]            adder_a,
  output logic                   adder_a_stb,
  input  logic                   adder_a_ack,
  output logic [31:0]            adder_b,
  output logic                   adder_b_stb,
  input  logic                   adder_b_ack,
  input  logic [31:0]            adder_z,
  input  logic                   adder_z_stb,
  output logic                   adder_z_ack,
  output logic                   busy
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [FpW-1:0]     op_a_q, op_a_d;
  logic [FpW-1:0]     op_b_q, op_b_d;
  logic [FpW-1:0]     res_q, res_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  rr_pick #(
    .NumReq(NUM_REQ),
    .IdW   (ID_W)
  ) u_rr_pick (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .gnt       (pick_gnt),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      owner_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      res_q        <= res_d;
    end
  end

  // Handshake outputs decode state only; ack inputs affect next state, never outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_d        = res_q;
    req_ready    = '0;
    resp_valid   = '0;
    resp_data    = '0;
    adder_a      = '0;
    adder_a_stb  = 1'b0;
    adder_b      = '0;
    adder_b_stb  = 1'b0;
    adder_z_ack  = 1'b0;
    busy         = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        req_ready = pick_gnt;
        if (pick_any) begin
          op_a_d  = req_a[32'(pick_idx) * FpW +: FpW];
          op_b_d  = req_b[32'(pick_idx) * FpW +: FpW];
          owner_d = pick_idx;
          state_d = StSendA;
        end
      end
      StSendA: begin
        adder_a_stb = 1'b1;
        adder_a     = op_a_q;
        if (adder_a_ack) state_d = StSendB;
      end
      StSendB: begin
        adder_b_stb = 1'b1;
        adder_b     = op_b_q;
        if (adder_b_ack) state_d = StWaitZ;
      end
      StWaitZ: begin
        adder_z_ack = 1'b1;
        if (adder_z_stb) begin
          res_d   = adder_z;
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid[owner_q] = 1'b1;
        resp_data           = res_q;
        if (resp_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_fpu_adder_arbiter.sv
// Bench for fpu_adder_arbiter: behavioural adder responder plus a result scoreboard.
module tb_fpu_adder_arbiter;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [32*NR-1:0] req_a = '0;
  logic [32*NR-1:0] req_b = '0;
  logic [NR-1:0]   req_ready, resp_valid;
  logic [NR-1:0]   resp_ready = '1;
  logic [31:0]     resp_data, adder_a, adder_b;
  logic [31:0]     adder_z = '0;
  logic            adder_a_stb, adder_b_stb, adder_z_ack, busy;
  logic            adder_a_ack = 1'b0;
  logic            adder_b_ack = 1'b0;
  logic            adder_z_stb = 1'b0;

  always #5 clk = ~clk;

  fpu_adder_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .adder_a    (adder_a),
    .adder_a_stb(adder_a_stb),
    .adder_a_ack(adder_a_ack),
    .adder_b    (adder_b),
    .adder_b_stb(adder_b_stb),
    .adder_b_ack(adder_b_ack),
    .adder_z    (adder_z),
    .adder_z_stb(adder_z_stb),
    .adder_z_ack(adder_z_ack),
    .busy       (busy)
  );

  typedef struct {
    int          owner;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  int          gnt_log[$];
  exp_t        mon_e;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;
  int          stall_a = 0;
  int          z_delay = 0;
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [31:0] ga = '0;
  logic [31:0] gb = '0;

  // Stand-in adder: known pairs give true FP sums, others an order-sensitive mix.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'hC0A00000 && b == 32'h40A00000) return 32'h00000000;
    return a ^ {b[30:0], b[31]};
  endfunction

  initial begin : adder_model
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        m_phase = 0; m_cnt = 0;
        adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0;
      end else begin
        case (m_phase)
          0: if (adder_a_ack) begin
               adder_a_ack = 1'b0; m_phase = 1; m_cnt = 0;
             end else if (adder_a_stb) begin
               if (m_cnt >= stall_a) begin adder_a_ack = 1'b1; ga = adder_a; end
               else m_cnt++;
             end
          1: if (adder_b_ack) begin
               adder_b_ack = 1'b0; m_phase = 2; m_cnt = 0;
             end else if (adder_b_stb) begin
               adder_b_ack = 1'b1; gb = adder_b;
             end
          default: if (adder_z_stb) begin
               adder_z_stb = 1'b0; m_phase = 0; m_cnt = 0;
             end else if (adder_z_ack) begin
               if (m_cnt >= z_delay) begin adder_z = fadd(ga, gb); adder_z_stb = 1'b1; end
               else m_cnt++;
             end
        endcase
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        if (req_ready != '0) begin
          checks++;
          if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
            errors++;
            $display("FAIL req_ready_onehot: req_ready=%b req_valid=%b, required one-hot subset",
                     req_ready, req_valid);
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            mon_e.owner = i;
            mon_e.data  = fadd(req_a[i*32 +: 32], req_b[i*32 +: 32]);
            sb.push_back(mon_e);
            gnt_log.push_back(i);
            cur_a = req_a[i*32 +: 32];
            cur_b = req_b[i*32 +: 32];
          end
        end
        if (adder_a_stb) begin
          checks++;
          if (adder_a !== cur_a) begin
            errors++;
            $display("FAIL adder_a_word: got %h, required %h", adder_a, cur_a);
          end
        end
        if (adder_b_stb) begin
          checks++;
          if (adder_b !== cur_b) begin
            errors++;
            $display("FAIL adder_b_word: got %h, required %h", adder_b, cur_b);
          end
        end
        if (resp_valid != '0) begin
          checks++;
          if ($countones(resp_valid) != 1) begin
            errors++;
            $display("FAIL resp_onehot: resp_valid=%b, required one-hot", resp_valid);
          end else begin
            for (int i = 0; i < NR; i++) begin
              if (resp_valid[i] && resp_ready[i]) begin
                checks++;
                if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL resp_unexpected: owner %0d data %h, required no response", i,
                           resp_data);
                end else begin
                  mon_e = sb.pop_front();
                  if (mon_e.owner != i || resp_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL resp_data: owner %0d data %h, required owner %0d data %h", i,
                             resp_data, mon_e.owner, mon_e.data);
                  end
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req_valid = '0; resp_ready = '1;
    tick();
    tick();
    rst = 1'b0;
    gnt_log.delete();
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic wait_grants(input int n);
    int c;
    c = 0;
    while (gnt_log.size() < n && c < 2000) begin @(negedge clk); #1; c++; end
    checks++;
    if (gnt_log.size() < n) begin
      errors++;
      $display("FAIL wait_grants: got %0d grants, required %0d", gnt_log.size(), n);
    end
  endtask

  task automatic wait_resp(input int i);
    int c;
    c = 0;
    while (!resp_valid[i] && c < 500) begin @(negedge clk); #1; c++; end
    checks++;
    if (!resp_valid[i]) begin
      errors++;
      $display("FAIL wait_resp: resp_valid=%b, required bit %0d set", resp_valid, i);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || busy) && c < 2000) begin @(negedge clk); #1; c++; end
    checks++;
    if (sb.size() != 0 || busy) begin
      errors++;
      $display("FAIL drain: pending=%0d busy=%b, required 0 and 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    @(negedge clk); #1;
    checks++;
    if ({busy, adder_a_stb, adder_b_stb, adder_z_ack, resp_valid, req_ready} !== '0 ||
        adder_a !== '0 || adder_b !== '0 || resp_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b stb=%b%b zack=%b rv=%b rr=%b a=%h b=%h d=%h, required 0",
               busy, adder_a_stb, adder_b_stb, adder_z_ack, resp_valid, req_ready, adder_a,
               adder_b, resp_data);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_priority: req_ready=%b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int c;
    do_reset();
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    wait_grants(1);
    tick();
    req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (!adder_a_stb || adder_a !== 32'h3F800000 || req_ready !== '0) begin
      errors++;
      $display("FAIL single_send_a: stb=%b a=%h rr=%b, required 1 3f800000 0000", adder_a_stb,
               adder_a, req_ready);
    end
    c = 0;
    while (!adder_b_stb && c < 100) begin @(negedge clk); #1; c++; end
    checks++;
    if (adder_b !== 32'h40000000) begin
      errors++;
      $display("FAIL single_send_b: b=%h, required 40000000", adder_b);
    end
    wait_resp(0);
    checks++;
    if (resp_data !== 32'h40400000) begin
      errors++;
      $display("FAIL single_result: resp_data=%h, required 40400000", resp_data);
    end
    drain();
    checks++;
    if (busy !== 1'b0 || gnt_log.size() != 1) begin
      errors++;
      $display("FAIL single_done: busy=%b grants=%0d, required 0 and 1", busy, gnt_log.size());
    end
  endtask

  task automatic check_order(input int n, input int exp_g[8]);
    checks++;
    if (gnt_log.size() != n) begin
      errors++;
      $display("FAIL grant_count: got %0d, required %0d", gnt_log.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (gnt_log[k] != exp_g[k]) begin
          errors++;
          $display("FAIL grant_order[%0d]: got %0d, required %0d", k, gnt_log[k], exp_g[k]);
        end
      end
    end
  endtask

  task automatic test_alternate();
    int exp_g[8];
    exp_g = '{0, 2, 0, 2, 0, 0, 0, 0};
    do_reset();
    set_op(0, 32'h11111111, 32'h22222222);
    set_op(2, 32'h33333333, 32'h44444444);
    req_valid = 4'b0101;
    wait_grants(4);
    tick();
    req_valid = '0;
    drain();
    check_order(4, exp_g);
  endtask

  task automatic test_all_four();
    int exp_g[8];
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 32'hA0000000 + i, 32'h0B000000 + 32'(i * 3));
    req_valid = 4'b1111;
    wait_grants(8);
    tick();
    req_valid = '0;
    drain();
    check_order(8, exp_g);
  endtask

  task automatic test_resp_stall();
    logic [31:0] held;
    do_reset();
    set_op(1, 32'h12345678, 32'h0F0F0F0F);
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    wait_grants(1);
    tick();
    req_valid = '0;
    wait_resp(1);
    held = resp_data;
    checks++;
    if (held !== fadd(32'h12345678, 32'h0F0F0F0F)) begin
      errors++;
      $display("FAIL stall_result: resp_data=%h, required %h", held,
               fadd(32'h12345678, 32'h0F0F0F0F));
    end
    tick();
    set_op(0, 32'h55555555, 32'h66666666);
    set_op(2, 32'h77777777, 32'h88888888);
    req_valid = 4'b0101;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 4'b0010 || resp_data !== held || req_ready !== '0 || !busy) begin
        errors++;
        $display("FAIL stall_hold[%0d]: rv=%b d=%h rr=%b busy=%b, required 0010 %h 0000 1", k,
                 resp_valid, resp_data, req_ready, busy, held);
      end
    end
    tick();
    resp_ready = '1;
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL stall_release: busy=%b rr=%b, required 0 0100", busy, req_ready);
    end
    tick();
    req_valid = '0;
    drain();
  endtask

  task automatic test_zero_stall();
    int n;
    do_reset();
    stall_a = 5;
    set_op(3, 32'hC0A00000, 32'h40A00000);
    req_valid = 4'b1000;
    wait_grants(1);
    tick();
    req_valid = '0;
    n = 0;
    @(negedge clk); #1;
    while (adder_a_stb && n < 100) begin
      checks++;
      if (adder_a !== 32'hC0A00000) begin
        errors++;
        $display("FAIL stall_a_word: a=%h, required c0a00000", adder_a);
      end
      n++;
      @(negedge clk); #1;
    end
    checks++;
    if (n < 6) begin
      errors++;
      $display("FAIL stall_a_len: stb cycles=%0d, required >= 6", n);
    end
    stall_a = 0;
    wait_resp(3);
    checks++;
    if (resp_data !== 32'h00000000) begin
      errors++;
      $display("FAIL zero_result: resp_data=%h, required 00000000", resp_data);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    z_delay = 50;
    set_op(2, 32'h0BADF00D, 32'h00C0FFEE);
    req_valid = 4'b0100;
    wait_grants(1);
    tick();
    req_valid = '0;
    c = 0;
    while (!adder_z_ack && c < 100) begin @(negedge clk); #1; c++; end
    checks++;
    if (!adder_z_ack) begin
      errors++;
      $display("FAIL mid_wait_z: adder_z_ack=%b, required 1", adder_z_ack);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    z_delay = 0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== '0 || adder_z_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b rv=%b zack=%b, required 0 0000 0", busy, resp_valid,
               adder_z_ack);
    end
    gnt_log.delete();
    for (int i = 0; i < NR; i++) set_op(i, 32'h3C000000 + 32'(i), 32'h00001000);
    tick();
    req_valid = 4'b1111;
    wait_grants(1);
    tick();
    req_valid = '0;
    drain();
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] != 0) begin
      errors++;
      $display("FAIL mid_after_grant: grants=%0d first=%0d, required 1 and 0", gnt_log.size(),
               (gnt_log.size() > 0) ? gnt_log[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_all_four();
    test_resp_stall();
    test_zero_stall();
    test_reset_mid();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
